id_ex_register: RTL
===================

# id_ex_register

Pipeline register between the decode stage and the execute stage of the 5-stage MIPS core. It captures the control unit's execute, memory and write-back buses together with the decoded operands. It also contains the load-use hazard detector: the detector stalls PC and IF/ID and inserts a bubble. Branch/jump flushes and the debug unit's single-step enable act on this register too.

## Interface
Parameters:
- `len_exec_bus`, 11, execute control bus width: bit10 Jump&Link, bit9 JALOnly, bit8 RegDst, bit7 ALUSrc1, bit6 ALUSrc2, bit5 jump, bit4 jump register, bits3:0 ALU code.
- `len_mem_bus`, 9, memory control bus width: bit8 BNE, bit7 SB, bit6 SH, bit5 LB, bit4 LH, bit3 Unsigned, bit2 Branch, bit1 MemRead, bit0 MemWrite.
- `len_wb_bus`, 2, write-back bus width: bit1 RegWrite, bit0 MemtoReg.
- `len_data`, 32, datapath width.
- `len_cnt`, 16, debug counter width.

Ports:
- `clk` in 1 — system clock. Everything updates on the rising edge.
- `rst_n` in 1 — reset, synchronous, active-low.
- `i_enable` in 1 — debug step enable. 0 holds all registers and counters.
- `i_flush` in 1 — branch/jump taken. The next capture is a bubble.
- `i_execute_bus` in len_exec_bus — from control unit.
- `i_memory_bus` in len_mem_bus — from control unit.
- `i_writeBack_bus` in len_wb_bus — from control unit.
- `i_pc_plus4` in len_data.
- `i_rs_data` in len_data.
- `i_rt_data` in len_data.
- `i_imm_ext` in len_data.
- `i_rs` in 5.
- `i_rt` in 5.
- `i_rd` in 5.
- `i_shamt` in 5.
- `o_execute_bus`, `o_memory_bus`, `o_writeBack_bus` out — registered control buses.
- `o_pc_plus4`, `o_rs_data`, `o_rt_data`, `o_imm_ext` out len_data — registered.
- `o_rs`, `o_rt`, `o_rd`, `o_shamt` out 5 — registered.
- `o_stall` out 1 — combinational. 1 freezes PC and IF/ID.
- `o_stall_count` out len_cnt — number of load-use bubbles inserted.
- `o_flush_count` out len_cnt — number of flush bubbles inserted.

## Operation
Hazard term:
- `hz = o_memory_bus[1] & (o_rt != 0) & ((o_rt == i_rs) | (o_rt == i_rt))`.
- `o_stall = i_enable & ~i_flush & hz`.
- The rt comparison is deliberately conservative: it applies to I-type instructions too.

Per-edge priority, highest first:
1. `rst_n == 0`: all outputs and counters are cleared to 0.
2. `i_enable == 0`: hold all registers and counters.
3. `i_flush == 1`: capture a bubble. `o_flush_count` increments.
4. `hz == 1`: capture a bubble. `o_stall_count` increments.
5. Otherwise: load all `i_*` inputs into the matching `o_*` outputs.

Bubble:
- All three control buses are written as 0.
- Data and index registers (pc, rs/rt data, imm, rs/rt/rd/shamt) are still loaded from the inputs. They have no effect with zero control.

Counters:
- Saturate at 2^len_cnt − 1; they do not wrap.

Hazard resolution:
- A stall lasts exactly one cycle. After the bubble, `o_memory_bus[1]` is 0, so `hz` drops.
- The held instruction is then loaded on the next edge.

## Timing
- Latency: 1 cycle from input to output. No combinational path from `i_*` to any registered output.
- `o_stall` is combinational from `i_rs`, `i_rt`, `i_enable`, `i_flush` and the registered `o_rt`/`o_memory_bus`. It is valid within the same cycle.
- Reset value of every output is 0, including `o_stall`, because `o_memory_bus` is 0 after reset.
- Flush and hazard in the same cycle: the flush wins. `o_stall` is 0, and only `o_flush_count` increments.
- `i_enable` low during a hazard: `o_stall` is 0 and the register holds. The hazard is re-evaluated once enable returns.
- Reset asserted mid-stall: the register clears on that edge and `o_stall` is 0 in the following cycle.
- Load into r0 (`o_rt == 0`) never stalls.

## Test plan
- **Reset:** hold rst_n=0 for 2 edges with random inputs → all outputs 0, o_stall=0. Release → first edge loads inputs.
- **Load-use:** LW ($8 ← mem) captured, then incoming ADD with rs=8 → o_stall=1 for one cycle and a zero-control bubble is captured. Next edge loads ADD with its buses. o_stall_count=1.
- **Load to r0 / no dependency:** LW with rt=0, incoming rs=0 → o_stall=0. LW rt=8 with incoming rs=9, rt=10 → o_stall=0.
- **Flush vs hazard:** LW rt=5 registered, incoming rs=5 and i_flush=1 → o_stall=0, bubble captured, o_flush_count=1, o_stall_count unchanged.
- **Enable hold:** i_enable=0 for 3 edges with changing inputs → outputs and counters unchanged, o_stall=0. Re-enable → normal loading resumes.
- **Saturation:** len_cnt=2, force 5 consecutive flushes → o_flush_count reads 1, 2, 3, 3, 3.

Source files
------------

// File: rtl/id_ex_register.sv
// id_ex_register: ID/EX pipeline register with load-use hazard detection, flush bubbles and debug step enable
module id_ex_register #(
    parameter int len_exec_bus = 11,
    parameter int len_mem_bus  = 9,
    parameter int len_wb_bus   = 2,
    parameter int len_data     = 32,
    parameter int len_cnt      = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    i_enable,
    input  logic                    i_flush,
    input  logic [len_exec_bus-1:0] i_execute_bus,
    input  logic [len_mem_bus-1:0]  i_memory_bus,
    input  logic [len_wb_bus-1:0]   i_writeBack_bus,
    input  logic [len_data-1:0]     i_pc_plus4,
    input  logic [len_data-1:0]     i_rs_data,
    input  logic [len_data-1:0]     i_rt_data,
    input  logic [len_data-1:0]     i_imm_ext,
    input  logic [4:0]              i_rs,
    input  logic [4:0]              i_rt,
    input  logic [4:0]              i_rd,
    input  logic [4:0]              i_shamt,
    output logic [len_exec_bus-1:0] o_execute_bus,
    output logic [len_mem_bus-1:0]  o_memory_bus,
    output logic [len_wb_bus-1:0]   o_writeBack_bus,
    output logic [len_data-1:0]     o_pc_plus4,
    output logic [len_data-1:0]     o_rs_data,
    output logic [len_data-1:0]     o_rt_data,
    output logic [len_data-1:0]     o_imm_ext,
    output logic [4:0]              o_rs,
    output logic [4:0]              o_rt,
    output logic [4:0]              o_rd,
    output logic [4:0]              o_shamt,
    output logic                    o_stall,
    output logic [len_cnt-1:0]      o_stall_count,
    output logic [len_cnt-1:0]      o_flush_count
);
    localparam logic [len_cnt-1:0] cnt_max = '1;
    logic hz;
    logic bubble;
    // Load in EX whose rt feeds the incoming instruction; rt match is conservative for I-type too
    always_comb begin
        hz = o_memory_bus[1] & (o_rt != 5'd0) & ((o_rt == i_rs) | (o_rt == i_rt));
        o_stall = i_enable & ~i_flush & hz;
        bubble = i_flush | hz;
    end
    // Capture next instruction; zero control on flush or hazard, flush taking priority in the counters
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            o_execute_bus   <= '0;
            o_memory_bus    <= '0;
            o_writeBack_bus <= '0;
            o_pc_plus4      <= '0;
            o_rs_data       <= '0;
            o_rt_data       <= '0;
            o_imm_ext       <= '0;
            o_rs            <= '0;
            o_rt            <= '0;
            o_rd            <= '0;
            o_shamt         <= '0;
            o_stall_count   <= '0;
            o_flush_count   <= '0;
        end else if (i_enable) begin
            o_execute_bus   <= bubble ? '0 : i_execute_bus;
            o_memory_bus    <= bubble ? '0 : i_memory_bus;
            o_writeBack_bus <= bubble ? '0 : i_writeBack_bus;
            o_pc_plus4      <= i_pc_plus4;
            o_rs_data       <= i_rs_data;
            o_rt_data       <= i_rt_data;
            o_imm_ext       <= i_imm_ext;
            o_rs            <= i_rs;
            o_rt            <= i_rt;
            o_rd            <= i_rd;
            o_shamt         <= i_shamt;
            o_flush_count   <= (i_flush && o_flush_count != cnt_max) ? o_flush_count + 1'b1 : o_flush_count;
            o_stall_count   <= (!i_flush && hz && o_stall_count != cnt_max) ? o_stall_count + 1'b1 : o_stall_count;
        end
    end
endmodule
